// File: rtl/leds.sv
// leds: board LED controller.
//   LEDR  constant-on power indicator
//   LEDG  heartbeat, toggles every CLK_HZ/(2*BLINK_HZ) enabled cycles
//   LEDB  breathing PWM, duty ramps 0..max..0 (only with LEDS_BREATHE_EN)
//
// Build option: define LEDS_BREATHE_EN to compile in the breathe engine.
//   Without it LEDB is constant 0.
//
// Ports:
//   CLK    in   single clock, rising edge
//   RST_N  in   synchronous active-low reset
//   EN     in   enable for blink and breathe engines
//   LEDR   out  red, 1 = lit
//   LEDG   out  green, 1 = lit
//   LEDB   out  blue, 1 = lit
//
// Breathe direction FSM:
//   state  | meaning
//   DIR_UP | duty increments on each step event
//   DIR_DN | duty decrements on each step event
module leds #(
   parameter int CLK_HZ       = 12000000,
   parameter int BLINK_HZ     = 1,
   parameter int PWM_BITS     = 8,
   parameter int STEP_PERIODS = 16
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic EN,
   output logic LEDR,
   output logic LEDG,
   output logic LEDB
);

   localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);

   generate
      if (PWM_BITS < 2 || PWM_BITS > 16 || STEP_PERIODS < 1 || HALF < 2) begin : g_bad_cfg
         $error("leds: illegal parameter set");
      end
   endgenerate

   assign LEDR = 1'b1;

   logic [BW-1:0] blink_cnt;
   logic          ledg_r;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         blink_cnt <= '0;
         ledg_r    <= 1'b0;
      end else if (EN) begin
         if (blink_cnt == HALF_M1) begin
            blink_cnt <= '0;
            ledg_r    <= ~ledg_r;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign LEDG = ledg_r;

`ifdef LEDS_BREATHE_EN
   localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_PERIODS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

   typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

   dir_t                dir_q, dir_d;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [SW-1:0]       step_cnt, step_d;
   logic                ledb_r;
   logic                period_end;
   logic                step_evt;

   always_comb begin
      period_end = EN && (pwm_cnt == DUTY_MAX);
      step_evt   = period_end && (step_cnt == STEP_LAST);
      dir_d      = dir_q;
      duty_d     = duty_q;
      step_d     = step_cnt;
      if (period_end) begin
         step_d = step_evt ? '0 : step_cnt + 1'b1;
      end
      // Direction flips on the step that lands on an end value, so duty
      // never wraps.
      if (step_evt) begin
         case (dir_q)
            DIR_UP: begin
               if (duty_q != DUTY_MAX) duty_d = duty_q + 1'b1;
               if (duty_d == DUTY_MAX) dir_d = DIR_DN;
            end
            default: begin
               if (duty_q != '0) duty_d = duty_q - 1'b1;
               if (duty_d == '0) dir_d = DIR_UP;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pwm_cnt  <= '0;
         step_cnt <= '0;
         duty_q   <= '0;
         dir_q    <= DIR_UP;
         ledb_r   <= 1'b0;
      end else begin
         if (EN) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            ledb_r  <= (pwm_cnt < duty_q);
         end else begin
            ledb_r  <= 1'b0;
         end
         step_cnt <= step_d;
         duty_q   <= duty_d;
         dir_q    <= dir_d;
      end
   end

   // Gate with EN so LEDB goes dark immediately when disabled.
   assign LEDB = ledb_r & EN;
`else
   assign LEDB = 1'b0;
`endif

endmodule

// File: tb/tb_leds.sv
module tb_leds;

   logic CLK = 1'b0;
   logic RST_N;
   logic EN;
   logic LEDR, LEDG, LEDB;

   int checks   = 0;
   int failures = 0;

   leds #(
      .CLK_HZ      (8),
      .BLINK_HZ    (1),
      .PWM_BITS    (2),
      .STEP_PERIODS(1)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .EN   (EN),
      .LEDR (LEDR),
      .LEDG (LEDG),
      .LEDB (LEDB)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic rst_n;
      logic en;
      logic ledg;
      logic ledb;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic g, input logic b);
      vec_t v;
      v.rst_n = r; v.en = e; v.ledg = g; v.ledb = b;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ledb_exp(input logic b);
`ifdef LEDS_BREATHE_EN
      return b;
`else
      return 1'b0;
`endif
   endfunction

   int exp_hi[8];
   int hi;
   int cyc;

   initial begin
      // LEDR is lit even with undriven inputs and no reset.
      for (int i = 0; i < 10; i++) begin
         #50;
         chk("ledr_undriven", LEDR, 1'b1);
      end

      // Cycle-by-cycle vectors: reset, ramp, EN pause, mid-ramp reset, restart.
      add(0,1, 0,0); add(0,1, 0,0);
      add(1,1, 0,0); add(1,1, 0,0); add(1,1, 0,0); add(1,1, 1,0);  // e1-e4  duty 0
      add(1,1, 1,1); add(1,1, 1,0); add(1,1, 1,0); add(1,1, 0,0);  // e5-e8  duty 1
      add(1,1, 0,1); add(1,1, 0,1); add(1,1, 0,0); add(1,1, 1,0);  // e9-e12 duty 2
      add(1,1, 1,1);                                               // e13    duty 3
      for (int i = 0; i < 10; i++) add(1,0, 1,0);                  // pause: hold LEDG, LEDB dark
      add(1,1, 1,1); add(1,1, 1,1); add(1,1, 0,0);                 // e14-e16 duty 3
      add(1,1, 0,1); add(1,1, 0,1);                                // e17-e18 duty 2 descending
      add(0,1, 0,0);                                               // reset mid-ramp
      add(1,1, 0,0); add(1,1, 0,0); add(1,1, 0,0); add(1,1, 1,0);  // restart duty 0
      add(1,1, 1,1); add(1,1, 1,0); add(1,1, 1,0); add(1,1, 0,0);  // duty 1

      @(negedge CLK);
      foreach (vecs[i]) begin
         RST_N = vecs[i].rst_n;
         EN    = vecs[i].en;
         @(posedge CLK);
         #1;
         chk($sformatf("vec%0d_ledg", i), LEDG, vecs[i].ledg);
         chk($sformatf("vec%0d_ledb", i), LEDB, ledb_exp(vecs[i].ledb));
         chk($sformatf("vec%0d_ledr", i), LEDR, 1'b1);
      end

      // Full ramp: LEDB high cycles per 4-cycle period, LEDG every 4 cycles.
`ifdef LEDS_BREATHE_EN
      exp_hi = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
      exp_hi = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
      RST_N = 1'b0; EN = 1'b1;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      cyc = 0;
      for (int p = 0; p < 8; p++) begin
         hi = 0;
         for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            cyc++;
            if (LEDB === 1'b1) hi++;
            if (k == 2) chk($sformatf("ramp_ledg_pre%0d", cyc), LEDG, logic'(p % 2));
            if (k == 3) chk($sformatf("ramp_ledg_tog%0d", cyc), LEDG, logic'((p + 1) % 2));
         end
         chk_int($sformatf("ramp_period%0d_high", p), hi, exp_hi[p]);
      end

      // Keep running to 100 enabled cycles; count LEDB highs in the tail.
      hi = 0;
      for (int k = 0; k < 68; k++) begin
         @(posedge CLK); #1;
         if (LEDB === 1'b1) hi++;
      end
      // Tail covers periods 8..24 of the triangle (duty 2,3,2,1,0,1,...).
`ifdef LEDS_BREATHE_EN
      chk_int("tail_ledb_high", hi, 2+3+2+1+0+1+2+3+2+1+0+1+2+3+2+1+0);
`else
      chk_int("tail_ledb_high", hi, 0);
`endif
      chk("tail_ledg", LEDG, 1'b1);  // 100 cycles -> 25 toggles -> lit

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/leds.md
LEDS -- requirements
Module: leds

Interface
REQ-001 Parameter CLK_HZ, default 12000000, SHALL set the input clock frequency in Hz.
REQ-002 Parameter BLINK_HZ, default 1, SHALL set the LEDG blink frequency in Hz; CLK_HZ/(2*BLINK_HZ) SHALL be >= 2.
REQ-003 Parameter PWM_BITS, default 8, SHALL set the PWM counter and duty width; legal range is 2-16.
REQ-004 Parameter STEP_PERIODS, default 16, SHALL set the number of PWM periods per duty step; it SHALL be >= 1.
REQ-005 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 RST_N  input  1  SHALL be the reset, which is synchronous and active-low.
REQ-007 EN  input  1  SHALL be the active-high enable for the blink and breathe engines.
REQ-008 LEDR  output  1  SHALL be the red power indicator; 1 means lit.
REQ-009 LEDG  output  1  SHALL be the green heartbeat; 1 means lit.
REQ-010 LEDB  output  1  SHALL be the blue breathing PWM; 1 means lit.

Function
REQ-011 LEDR SHALL be tied to constant 1, independent of CLK, RST_N and EN, including when those inputs are undriven or X.
REQ-012 HALF SHALL equal CLK_HZ/(2*BLINK_HZ), using integer division evaluated at elaboration.
REQ-013 The blink counter SHALL increment each cycle while EN=1. On reaching HALF-1 it SHALL wrap to 0 in the same cycle that LEDG toggles.
REQ-014 While EN=0, the blink counter and LEDG SHALL hold their values.
REQ-015 pwm_cnt (PWM_BITS wide) SHALL increment each cycle while EN=1 and wrap from all-ones to 0; each wrap SHALL mark a period end.
REQ-016 LEDB SHALL be registered as (pwm_cnt < duty), giving 1-cycle latency. Duty 0 SHALL give LEDB constantly 0; duty all-ones SHALL give 2^PWM_BITS-1 high cycles per period.
REQ-017 A step counter SHALL count period ends. After STEP_PERIODS period ends it SHALL clear and duty SHALL step by 1 in the current direction.
REQ-018 The direction SHALL reverse to down when duty reaches all-ones and to up when duty reaches 0. Duty SHALL never wrap.
REQ-019 While EN=0, pwm_cnt, the step counter, duty and direction SHALL hold, and LEDB SHALL be forced to 0.
REQ-020 If EN and a wrap or step event occur in the same cycle, the event SHALL be processed normally.

Reset
REQ-021 When RST_N=0 at a rising CLK edge, the block SHALL clear: blink counter 0, LEDG 0, pwm_cnt 0, step counter 0, duty 0, direction up, LEDB 0.
REQ-022 Reset SHALL take priority over EN. Asserting reset mid-ramp or mid-blink SHALL restart all sequences from the cleared state.
REQ-023 LEDR SHALL be unaffected by reset.

Configuration
REQ-024 With macro LEDS_BREATHE_EN defined, the PWM breathe engine (REQ-015 to REQ-020) SHALL be compiled in.
REQ-025 Without LEDS_BREATHE_EN, the breathe engine SHALL be omitted, LEDB SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification
REQ-026 Ports undriven, simulate 1 us -> LEDR=1 throughout.
REQ-027 CLK_HZ=8, BLINK_HZ=1, hold reset then release with EN=1 -> LEDG rises at the 4th edge after release and toggles every 4 cycles thereafter.
REQ-028 PWM_BITS=2, STEP_PERIODS=1, LEDS_BREATHE_EN defined, EN=1 -> duty follows 0,1,2,3,2,1,0,1, changing every 4 cycles; LEDB is high 0,1,2,3,2,1 cycles per period.
REQ-029 Deassert EN mid-blink for 10 cycles -> LEDG holds, LEDB is 0, and counting resumes from the held values when EN returns to 1.
REQ-030 Assert RST_N=0 for 1 cycle with duty=2 descending -> next cycle has duty 0, direction up, LEDG 0, LEDB 0, LEDR 1.
REQ-031 Build without LEDS_BREATHE_EN, EN=1 for 100 cycles -> LEDB stays 0 and the LEDG timing matches REQ-027.
